// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage with IF/ID pipeline register. Holds the PC, fetches
//   over a req/ack handshake to variable-latency instruction memory and presents
//   {instr, pc+4, valid} to ID. Honours load-use stall (one-entry skid buffer
//   catches an instruction acked while stalled) and branch flush/redirect (a
//   wrong-path access still outstanding is drained and its data discarded).
//
// Optional feature: define FETCH_PERF_EN to build the two 32-bit performance
//   counters; when undefined both counter ports are tied to zero.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   stall             hold PC and IF/ID this cycle
//   flush             kill IF/ID, redirect PC to branch_target
//   branch_target     redirect address, sampled when flush=1
//   imem_req/addr     fetch request and address (addr = PC)
//   imem_ack/rdata    memory response
//   instr_out/pc4_out/valid_out   IF/ID register contents
//   perf_fetch_cnt    valid instructions loaded into IF/ID
//   perf_bubble_cnt   bubbles loaded into IF/ID
// ----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic [PC_W-1:0]    branch_target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc4_out,
    output logic               valid_out,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_bubble_cnt
);

    typedef enum logic [1:0] {StRst, StFetch, StHold, StDrain} state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    tgt_q, tgt_d;
    logic [INSTR_W-1:0] skid_q, skid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc4_q, pc4_d;
    logic               valid_q, valid_d;

    logic               load_valid, load_bubble;
    logic [INSTR_W-1:0] new_instr;
    logic [PC_W-1:0]    new_pc4;
    logic [PC_W-1:0]    pc_plus4;

    assign pc_plus4  = pc_q + PC_W'(4);
    assign imem_req  = (state_q == StFetch) || (state_q == StDrain);
    assign imem_addr = pc_q;
    assign instr_out = instr_q;
    assign pc4_out   = pc4_q;
    assign valid_out = valid_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        skid_d      = skid_q;
        load_valid  = 1'b0;
        load_bubble = 1'b0;
        new_instr   = imem_rdata;
        new_pc4     = pc_plus4;

        unique case (state_q)
            StRst: state_d = StFetch;
            StFetch: begin
                if (flush) begin
                    load_bubble = 1'b1;
                    if (imem_ack) begin
                        pc_d = branch_target;
                    end else begin
                        // Request must stay up until acked; remember where to go.
                        tgt_d   = branch_target;
                        state_d = StDrain;
                    end
                end else if (imem_ack) begin
                    pc_d = pc_plus4;
                    if (stall) begin
                        skid_d  = imem_rdata;
                        state_d = StHold;
                    end else begin
                        load_valid = 1'b1;
                    end
                end else if (!stall) begin
                    load_bubble = 1'b1;
                end
            end
            StHold: begin
                if (flush) begin
                    load_bubble = 1'b1;
                    pc_d        = branch_target;
                    state_d     = StFetch;
                end else if (!stall) begin
                    // pc already advanced when the skid was filled, so pc = old pc + 4.
                    load_valid = 1'b1;
                    new_instr  = skid_q;
                    new_pc4    = pc_q;
                    state_d    = StFetch;
                end
            end
            StDrain: begin
                if (imem_ack) begin
                    pc_d    = flush ? branch_target : tgt_q;
                    state_d = StFetch;
                end else if (flush) begin
                    tgt_d = branch_target;
                end
            end
            default: state_d = StRst;
        endcase

        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (load_bubble) begin
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (load_valid) begin
            instr_d = new_instr;
            pc4_d   = new_pc4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRst;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            skid_q  <= '0;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            skid_q  <= skid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (load_valid)  fetch_cnt_q  <= fetch_cnt_q + 32'd1;
            if (load_bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`else
    assign perf_fetch_cnt  = 32'h0;
    assign perf_bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_stage
//   Self-checking bench for if_fetch_stage: directed scenarios followed by
//   randomized stall/flush/ack traffic, compared each cycle against a
//   transaction-level reference model (PC, pending wrong-path flag, skid queue).
// ----------------------------------------------------------------------------
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr_out;
    logic [31:0] pc4_out;
    logic        valid_out;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;

    if_fetch_stage #(
        .PC_W     (32),
        .INSTR_W  (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .branch_target   (branch_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr_out       (instr_out),
        .pc4_out         (pc4_out),
        .valid_out       (valid_out),
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Memory contents: a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_0001;
    endfunction

    // ---------------- reference model ----------------
    bit          m_started;   // first edge after reset seen
    bit          m_wrong;     // wrong-path access still outstanding
    logic [31:0] m_pc, m_tgt;
    logic [31:0] m_skid[$];   // instruction caught during stall (at most one)
    logic [31:0] m_instr, m_pc4;
    bit          m_valid;
    logic [31:0] m_nfetch, m_nbubble;

    function automatic bit m_req();
        return m_started && (m_skid.size() == 0);
    endfunction

    task automatic m_reset();
        m_started = 0; m_wrong = 0; m_pc = 32'h0; m_tgt = 32'h0;
        m_skid.delete();
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0;
        m_nfetch = 0; m_nbubble = 0;
    endtask

    task automatic m_bubble();
        m_instr = 0; m_pc4 = 0; m_valid = 0; m_nbubble++;
    endtask

    task automatic m_deliver(input logic [31:0] ins, input logic [31:0] p4);
        m_instr = ins; m_pc4 = p4; m_valid = 1; m_nfetch++;
    endtask

    task automatic m_step(input bit st, input bit fl, input logic [31:0] bt,
                          input bit ak, input logic [31:0] data);
        if (!m_started) begin
            m_started = 1;
        end else if (m_skid.size() != 0) begin
            if (fl) begin
                m_skid.delete(); m_bubble(); m_pc = bt;
            end else if (!st) begin
                m_deliver(m_skid.pop_front(), m_pc);
            end
        end else if (m_wrong) begin
            if (ak) begin
                m_pc = fl ? bt : m_tgt; m_wrong = 0;
            end else if (fl) begin
                m_tgt = bt;
            end
        end else if (fl) begin
            m_bubble();
            if (ak) m_pc = bt;
            else begin m_tgt = bt; m_wrong = 1; end
        end else if (ak) begin
            if (st) m_skid.push_back(data);
            else m_deliver(data, m_pc + 32'd4);
            m_pc = m_pc + 32'd4;
        end else if (!st) begin
            m_bubble();
        end
    endtask

    task automatic check_all();
        check("req",   64'(imem_req),   64'(m_req()));
        check("addr",  64'(imem_addr),  64'(m_pc));
        check("instr", 64'(instr_out),  64'(m_instr));
        check("pc4",   64'(pc4_out),    64'(m_pc4));
        check("valid", 64'(valid_out),  64'(m_valid));
`ifdef FETCH_PERF_EN
        check("perf_fetch",  64'(perf_fetch_cnt),  64'(m_nfetch));
        check("perf_bubble", 64'(perf_bubble_cnt), 64'(m_nbubble));
`else
        check("perf_fetch",  64'(perf_fetch_cnt),  64'h0);
        check("perf_bubble", 64'(perf_bubble_cnt), 64'h0);
`endif
    endtask

    // One clock: drive inputs (called just after an edge), advance model, check.
    task automatic cycle(input bit st, input bit fl, input logic [31:0] bt, input bit ak);
        logic [31:0] data;
        bit          a;
        a    = ak && m_req();
        data = mem_word(m_pc);
        stall = st; flush = fl; branch_target = bt;
        imem_ack = a; imem_rdata = a ? data : 32'hxxxx_xxxx;
        m_step(st, fl, bt, a, data);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ack = 1'b0; stall = 1'b0; flush = 1'b0;
        #1;
        m_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2;
        do_reset();
        check("rst_req", 64'(imem_req), 64'h0);

        // Zero-wait memory: one instruction per cycle.
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check("zw_addr", 64'(imem_addr), 64'(4 * i));
            cycle(0, 0, 0, 1);
            check("zw_pc4",   64'(pc4_out),   64'(4 * i + 4));
            check("zw_valid", 64'(valid_out), 64'h1);
        end

        // Two-cycle ack delay at 0x10.
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 0, 0);
            check("wait_valid", 64'(valid_out), 64'h0);
            check("wait_addr",  64'(imem_addr), 64'h10);
            check("wait_req",   64'(imem_req),  64'h1);
        end
        cycle(0, 0, 0, 1);
        check("wait_pc4", 64'(pc4_out), 64'h14);

        // Advance to 0x20, then stall three cycles while 0x20 acks.
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 1);
        check("stall_req", 64'(imem_req), 64'h0);
        check("stall_pc4", 64'(pc4_out),  64'h20);
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        check("stall_hold", 64'(pc4_out), 64'h20);
        cycle(0, 0, 0, 0);
        check("unstall_instr", 64'(instr_out), 64'(mem_word(32'h20)));
        check("unstall_addr",  64'(imem_addr), 64'h24);

        // Flush with access pending: drain, discard, redirect to 0x100.
        cycle(0, 1, 32'h100, 0);
        check("drain_valid", 64'(valid_out), 64'h0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        check("drain_addr",  64'(imem_addr), 64'h100);
        check("drain_valid2", 64'(valid_out), 64'h0);

        // Flush and stall together while holding a skid.
        cycle(1, 0, 0, 1);
        cycle(1, 1, 32'h200, 0);
        check("hold_flush_addr",  64'(imem_addr), 64'h200);
        check("hold_flush_valid", 64'(valid_out), 64'h0);

        // Reset pulse in the middle of a wait.
        cycle(0, 0, 0, 0);
        do_reset();
        check("midrst_req",  64'(imem_req),  64'h0);
        check("midrst_addr", 64'(imem_addr), 64'h0);

        // 10 valid loads then 3 bubbles.
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
`ifdef FETCH_PERF_EN
        check("perf10", 64'(perf_fetch_cnt),  64'd10);
        check("perf3",  64'(perf_bubble_cnt), 64'd3);
`else
        check("perf10", 64'(perf_fetch_cnt),  64'd0);
        check("perf3",  64'(perf_bubble_cnt), 64'd0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) == 0,
                      $urandom_range(0, 9) == 0,
                      {$urandom_range(0, 32'h3FFF), 2'b00},
                      $urandom_range(0, 1) == 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
